// File: rtl/ifu_fetch_seq.sv
// ifu_fetch_seq: single-outstanding instruction-fetch sequencer.
// Owns the fetch PC, issues one imem request at a time, holds the returned
// instruction for the predecoder and IDU, and applies EXU redirects.
module ifu_fetch_seq #(
    parameter int unsigned      PC_W     = 32,
    parameter int unsigned      INST_W   = 32,
    parameter logic [PC_W-1:0]  RESET_PC = 32'h8000_0000
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    // instruction memory request channel
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [PC_W-1:0]   imem_req_addr_o,
    // instruction memory response channel
    input  logic              imem_resp_valid_i,
    input  logic [INST_W-1:0] imem_resp_data_i,
    output logic              imem_resp_ready_o,
    // predecoder
    output logic [INST_W-1:0] pd_inst_o,
    output logic [PC_W-1:0]   pd_pc_o,
    input  logic [PC_W-1:0]   pd_pred_pc_i,
    // IDU
    output logic              id_valid_o,
    input  logic              id_ready_i,
    output logic [INST_W-1:0] id_inst_o,
    output logic [PC_W-1:0]   id_pc_o,
    output logic [PC_W-1:0]   id_pred_pc_o,
    // EXU redirect
    input  logic              redirect_valid_i,
    input  logic [PC_W-1:0]   redirect_pc_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PC_W-1:0]     r_pc;
    logic [PC_W-1:0]     w_pc_nxt;
    logic                r_drop;
    logic                w_drop_nxt;
    logic [INST_W-1:0]   r_inst;
    logic [INST_W-1:0]   w_inst_nxt;
    logic [PC_W-1:0]     r_ipc;
    logic [PC_W-1:0]     w_ipc_nxt;

    logic                w_req_fire;
    logic                w_resp_fire;
    logic                w_id_fire;

    // Handshake outputs decoded from the current state
    always_comb begin
        imem_req_valid_o  = (r_state == S_REQ);
        imem_resp_ready_o = (r_state == S_WAIT);
        // A redirect kills the held instruction in the same cycle
        id_valid_o        = (r_state == S_HOLD) & ~redirect_valid_i;
        imem_req_addr_o   = r_pc;
        pd_inst_o         = r_inst;
        pd_pc_o           = r_ipc;
        id_inst_o         = r_inst;
        id_pc_o           = r_ipc;
        id_pred_pc_o      = pd_pred_pc_i;
        w_req_fire        = imem_req_valid_o & imem_req_ready_i;
        w_resp_fire       = imem_resp_valid_i & imem_resp_ready_o;
        w_id_fire         = id_valid_o & id_ready_i;
    end

    // Next-state logic; redirect takes priority in every state but S_IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_drop_nxt  = r_drop;
        w_inst_nxt  = r_inst;
        w_ipc_nxt   = r_ipc;
        case (r_state)
            S_IDLE: begin
                // Keeps the reset-release cycle free of requests
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (redirect_valid_i) begin
                    w_pc_nxt = redirect_pc_i;
                end
                if (w_req_fire) begin
                    w_state_nxt = S_WAIT;
                    // Request left with the old address: its data must be dropped
                    w_drop_nxt  = redirect_valid_i;
                end
            end
            S_WAIT: begin
                if (redirect_valid_i) begin
                    w_pc_nxt = redirect_pc_i;
                    if (w_resp_fire) begin
                        w_state_nxt = S_REQ;
                        w_drop_nxt  = 1'b0;
                    end else begin
                        w_drop_nxt  = 1'b1;
                    end
                end else if (w_resp_fire) begin
                    if (r_drop) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_inst_nxt  = imem_resp_data_i;
                        w_ipc_nxt   = r_pc;
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid_i) begin
                    w_pc_nxt    = redirect_pc_i;
                    w_state_nxt = S_REQ;
                end else if (w_id_fire) begin
                    w_pc_nxt    = pd_pred_pc_i;
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_drop  <= 1'b0;
            r_inst  <= '0;
            r_ipc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_drop  <= w_drop_nxt;
            r_inst  <= w_inst_nxt;
            r_ipc   <= w_ipc_nxt;
        end
    end

    // Fetch PC must stay word aligned; EXU and predecoder guarantee it
    a_pc_aligned: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        r_pc[1:0] == 2'b00);

endmodule

// File: tb/tb_ifu_fetch_seq.sv
// Directed bench for ifu_fetch_seq with a small imem responder and a
// predecoder stub (sequential PC+4, one jal at 0x8000_000C -> 0x8000_0100).
module tb_ifu_fetch_seq;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_ready;
    logic [31:0] pd_inst;
    logic [31:0] pd_pc;
    logic [31:0] pd_pred_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pred_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned hs_cnt   = 0;
    int unsigned hs_ref   = 0;

    // imem responder state
    logic        mem_pend;
    logic [31:0] mem_addr;
    int unsigned mem_cnt;
    int unsigned resp_lat;

    ifu_fetch_seq #(
        .PC_W     (32),
        .INST_W   (32),
        .RESET_PC (32'h8000_0000)
    ) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .imem_req_valid_o  (imem_req_valid),
        .imem_req_ready_i  (imem_req_ready),
        .imem_req_addr_o   (imem_req_addr),
        .imem_resp_valid_i (imem_resp_valid),
        .imem_resp_data_i  (imem_resp_data),
        .imem_resp_ready_o (imem_resp_ready),
        .pd_inst_o         (pd_inst),
        .pd_pc_o           (pd_pc),
        .pd_pred_pc_i      (pd_pred_pc),
        .id_valid_o        (id_valid),
        .id_ready_i        (id_ready),
        .id_inst_o         (id_inst),
        .id_pc_o           (id_pc),
        .id_pred_pc_o      (id_pred_pc),
        .redirect_valid_i  (redirect_valid),
        .redirect_pc_i     (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Responder: accepts a request, answers resp_lat cycles after the WAIT cycle begins
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_pend <= 1'b0;
            mem_addr <= '0;
            mem_cnt  <= 0;
        end else if (imem_req_valid && imem_req_ready) begin
            mem_pend <= 1'b1;
            mem_addr <= imem_req_addr;
            mem_cnt  <= resp_lat;
        end else if (mem_pend) begin
            if (mem_cnt == 0) begin
                if (imem_resp_ready) mem_pend <= 1'b0;
            end else begin
                mem_cnt <= mem_cnt - 1;
            end
        end
    end
    assign imem_resp_valid = mem_pend && (mem_cnt == 0);
    assign imem_resp_data  = inst_of(mem_addr);

    // Predecoder stub
    assign pd_pred_pc = (pd_pc == 32'h8000_000C) ? 32'h8000_0100 : pd_pc + 32'd4;

    // IDU handshake counter
    always @(posedge clk) begin
        if (rst_n && id_valid && id_ready) hs_cnt = hs_cnt + 1;
    end

    a_resp_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
        imem_resp_valid |-> imem_resp_ready)
        else $error("FAIL resp_outside_wait: response presented while resp_ready=0");

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        resp_lat       = 0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_req_valid",  {31'b0, imem_req_valid},  32'd0);
        check("rst_resp_ready", {31'b0, imem_resp_ready}, 32'd0);
        check("rst_id_valid",   {31'b0, id_valid},        32'd0);
        check("rst_req_addr",   imem_req_addr,            32'h8000_0000);
        check("rst_pd_inst",    pd_inst,                  32'd0);
        check("rst_pd_pc",      pd_pc,                    32'd0);

        rst_n = 1'b1;
        #1;
        check("idle_no_req", {31'b0, imem_req_valid}, 32'd0);

        // Sequential fetch, 0-wait memory: REQ, WAIT, HOLD per instruction
        @(negedge clk);
        for (int unsigned k = 0; k < 3; k++) begin
            check("seq_req_valid", {31'b0, imem_req_valid}, 32'd1);
            check("seq_req_addr",  imem_req_addr, 32'h8000_0000 + 4 * k);
            @(negedge clk);
            check("seq_resp_ready", {31'b0, imem_resp_ready}, 32'd1);
            check("seq_wait_no_id", {31'b0, id_valid}, 32'd0);
            @(negedge clk);
            check("seq_id_valid", {31'b0, id_valid}, 32'd1);
            check("seq_id_pc",    id_pc,   32'h8000_0000 + 4 * k);
            check("seq_id_inst",  id_inst, inst_of(32'h8000_0000 + 4 * k));
            check("seq_pred_pc",  id_pred_pc, 32'h8000_0004 + 4 * k);
            check("seq_pd_pc",    pd_pc,   32'h8000_0000 + 4 * k);
            @(negedge clk);
        end

        // jal at 0x8000_000C predicted to 0x8000_0100
        check("jal_req_addr", imem_req_addr, 32'h8000_000C);
        @(negedge clk);
        @(negedge clk);
        check("jal_id_pc",      id_pc,      32'h8000_000C);
        check("jal_id_pred_pc", id_pred_pc, 32'h8000_0100);
        @(negedge clk);
        check("jal_next_addr",  imem_req_addr, 32'h8000_0100);
        check("jal_next_valid", {31'b0, imem_req_valid}, 32'd1);

        // IDU stall for 5 cycles in HOLD
        id_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int unsigned i = 0; i < 5; i++) begin
            check("stall_id_valid",  {31'b0, id_valid}, 32'd1);
            check("stall_id_pc",     id_pc,   32'h8000_0100);
            check("stall_id_inst",   id_inst, inst_of(32'h8000_0100));
            check("stall_no_req",    {31'b0, imem_req_valid}, 32'd0);
            if (i < 4) @(negedge clk);
        end
        id_ready = 1'b1;
        @(negedge clk);
        check("stall_next_addr", imem_req_addr, 32'h8000_0104);
        check("stall_next_valid", {31'b0, imem_req_valid}, 32'd1);

        // Redirect in WAIT; response arrives 2 cycles later and is dropped
        hs_ref   = hs_cnt;
        resp_lat = 2;
        @(negedge clk);
        check("rdw_resp_ready", {31'b0, imem_resp_ready}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0040;
        resp_lat       = 0;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("rdw_still_wait", {31'b0, imem_resp_ready}, 32'd1);
        check("rdw_no_id_1",    {31'b0, id_valid}, 32'd0);
        @(negedge clk);
        check("rdw_no_id_2",    {31'b0, id_valid}, 32'd0);
        @(negedge clk);
        check("rdw_req_valid",  {31'b0, imem_req_valid}, 32'd1);
        check("rdw_req_addr",   imem_req_addr, 32'h8000_0040);
        check("rdw_no_id_3",    {31'b0, id_valid}, 32'd0);
        check("rdw_no_hs",      hs_cnt, hs_ref);

        // Redirect in HOLD with IDU ready: instruction killed
        @(negedge clk);
        @(negedge clk);
        check("rdh_id_valid_pre", {31'b0, id_valid}, 32'd1);
        check("rdh_id_pc_pre",    id_pc, 32'h8000_0040);
        hs_ref         = hs_cnt;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0080;
        #1;
        check("rdh_id_masked", {31'b0, id_valid}, 32'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        check("rdh_req_addr", imem_req_addr, 32'h8000_0080);
        check("rdh_no_hs",    hs_cnt, hs_ref);

        // Redirect on an unaccepted request: new address next cycle
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_00C0;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("rdr_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("rdr_req_addr",  imem_req_addr, 32'h8000_00C0);
        imem_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rdr_id_valid", {31'b0, id_valid}, 32'd1);
        check("rdr_id_pc",    id_pc, 32'h8000_00C0);
        @(negedge clk);
        check("rdr_next_addr", imem_req_addr, 32'h8000_00C4);

        // Asynchronous reset while waiting on a response
        resp_lat = 3;
        @(negedge clk);
        check("rstw_in_wait", {31'b0, imem_resp_ready}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstw_req_valid",  {31'b0, imem_req_valid},  32'd0);
        check("rstw_resp_ready", {31'b0, imem_resp_ready}, 32'd0);
        check("rstw_id_valid",   {31'b0, id_valid},        32'd0);
        check("rstw_req_addr",   imem_req_addr,            32'h8000_0000);
        check("rstw_pd_inst",    pd_inst,                  32'd0);
        resp_lat = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rstw_idle", {31'b0, imem_req_valid}, 32'd0);
        @(negedge clk);
        check("rstw_req_valid2", {31'b0, imem_req_valid}, 32'd1);
        check("rstw_req_addr2",  imem_req_addr, 32'h8000_0000);
        @(negedge clk);
        @(negedge clk);
        check("rstw_id_valid2", {31'b0, id_valid}, 32'd1);
        check("rstw_id_pc2",    id_pc,   32'h8000_0000);
        check("rstw_id_inst2",  id_inst, inst_of(32'h8000_0000));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
